div_array_sequencer: RTL
========================

// Module: div_array_sequencer
// PURPOSE
// - Registered issue/capture stage wrapped around the combinational 16/8 restoring divider array.
// - Accepts a dividend/divisor pair on a valid/ready handshake and screens it for divide-by-zero and quotient overflow.
// - Holds the operands stable on the array inputs for a programmable settle time, then captures q/r.
// - Presents q/r downstream on a valid/ready handshake, with status flags.
// PARAMETERS
// - SETTLE_CYCLES  2  cycles operands are held on the array before capture; legal range 1..15
// PORTS
// - clk        in   1   system clock; all state updates on rising edge
// - rst        in   1   synchronous reset, active-high
// - in_valid   in   1   operand pair valid
// - in_ready   out  1   stage can accept an operand pair
// - in_n       in   16  dividend
// - in_d       in   8   divisor
// - arr_n      out  16  registered dividend driven to the divider array
// - arr_d      out  8   registered divisor driven to the divider array
// - arr_q      in   8   quotient returned by the divider array
// - arr_r      in   8   remainder returned by the divider array
// - out_valid  out  1   result valid
// - out_ready  in   1   downstream accepts result
// - out_q      out  8   captured quotient
// - out_r      out  8   captured remainder
// - out_dz     out  1   divide-by-zero flag (in_d == 0)
// - out_ovf    out  1   quotient overflow flag (in_n[15:8] >= in_d, in_d != 0)
// - out_err    out  1   residual mismatch flag (see CONFIGURATION)
// BEHAVIOUR
// - Reset: state IDLE, settle counter 0. All of the following are 0: in_ready, arr_n, arr_d, out_valid, out_q, out_r, out_dz, out_ovf, out_err.
//   in_ready rises in the first cycle after rst deasserts.
// - States:
//   - IDLE: in_ready = 1. On in_valid: register in_n/in_d into arr_n/arr_d and compute dz/ovf.
//     If in_d == 0, go to HOLD; otherwise go to SETTLE with counter = SETTLE_CYCLES-1.
//   - SETTLE: in_ready = 0; arr_n/arr_d held stable. Counter decrements each cycle.
//     In the cycle the counter is 0, capture arr_q/arr_r into out_q/out_r and go to HOLD.
//   - HOLD: out_valid = 1. out_q/r/dz/ovf/err are stable while out_ready = 0. in_ready = out_ready.
//     On out_ready & in_valid: retire the result and accept the new pair in the same edge (IDLE acceptance rules apply).
//     On out_ready & !in_valid: go to IDLE and drop out_valid.
// - Latency: a pair accepted at edge k gives out_valid high after edge k+SETTLE_CYCLES; for dz, after edge k+1.
// - Throughput: one result per SETTLE_CYCLES+1 cycles under continuous valid/ready; dz pairs run one per cycle.
// - Divide-by-zero: no settle; out_q = 8'hFF, out_r = in_n[7:0], out_dz = 1, out_ovf = 0, out_err = 0.
// - Overflow: the pair still goes through the array; out_ovf = 1 and out_q/out_r are the raw array values.
// - Flags are computed from the accepted operands and registered alongside them. They are never derived from arr_q/arr_r.
// - in_ready depends combinationally on out_ready in HOLD only. No other combinational input-to-output paths.
// - Reset mid-operation: the in-flight pair is discarded with no output pulse; all outputs return to reset values the next cycle.
// - in_n/in_d are ignored while in_ready = 0; changes on arr_q/arr_r outside the capture cycle have no effect.
// CONFIGURATION
// - DIV_RESID_CHECK_EN defined: at capture, out_err = ({1'b0,arr_q*arr_d} + arr_r != {1'b0,arr_n}) | (arr_r >= arr_d).
//   - Uses a 17-bit compare; the check is skipped (out_err = 0) when ovf or dz is set.
//   - Monitors the approximate array at run time.
// - DIV_RESID_CHECK_EN undefined: out_err is tied to 0 and no multiplier or comparator is built. The port is always present.
// TESTING (the bench models the array; it drives arr_q/arr_r from arr_n/arr_d after SETTLE_CYCLES-1 cycles)
// - Nominal: SETTLE_CYCLES=2, n=100, d=7, out_ready=1 -> out_valid 2 cycles after accept; q=14, r=2; dz=ovf=err=0.
// - Divide-by-zero: n=16'h12AB, d=0 -> out_valid 1 cycle after accept; q=8'hFF, r=8'hAB, dz=1, array inputs still registered.
// - Overflow: n=16'h0800, d=8 -> ovf=1, dz=0; out_q/out_r equal whatever the model drives.
// - Backpressure: out_ready=0 for 5 cycles after out_valid -> q/r/flags stable, in_ready=0.
//   Then out_ready=1 with in_valid=1 -> retire and accept on the same edge; the next result follows 2 cycles later.
// - Reset mid-SETTLE: assert rst one cycle after accept -> out_valid never pulses; all outputs 0.
//   in_ready=1 in the cycle after rst falls.
// - Residual check (macro defined): n=100, d=7, model forces q=13, r=2 -> out_err=1.
//   Correct q=14 -> out_err=0. Macro undefined -> out_err=0 in both cases.

Source files
------------

// File: rtl/div_array_sequencer.sv
// div_array_sequencer
// Issue/capture stage around a combinational 16/8 restoring divider array.
// Accepts a dividend/divisor pair on a valid/ready handshake. It screens the
// pair for divide-by-zero and quotient overflow. It then holds the operands on
// the array for SETTLE_CYCLES and captures the quotient and remainder.
// Optional feature: define DIV_RESID_CHECK_EN to build the run-time residual
// check that drives out_err. When the macro is undefined, out_err is tied to 0.
module div_array_sequencer #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_n,
  input  logic [7:0]  in_d,
  output logic [15:0] arr_n,
  output logic [7:0]  arr_d,
  input  logic [7:0]  arr_q,
  input  logic [7:0]  arr_r,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_q,
  output logic [7:0]  out_r,
  output logic        out_dz,
  output logic        out_ovf,
  output logic        out_err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HOLD   = 2'd2
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYCLES - 1);

  state_t     state;
  logic [3:0] cnt;
  logic       rdy_p0;   // registered "idle and out of reset" ready
  logic       ovf_p1;   // overflow flag travelling with the operands on the array
  logic       accept;
  logic       dz_c;
  logic       ovf_c;
  logic       err_c;

`ifdef DIV_RESID_CHECK_EN
  // Recombine q*d + r and compare against the dividend in 17 bits.
  // Also flag a remainder that is not strictly below the divisor.
  function automatic logic resid_err(input logic [15:0] n, input logic [7:0] d,
                                     input logic [7:0] q, input logic [7:0] r);
    logic [15:0] prod;
    logic [16:0] recomb;
    prod   = 16'(q) * 16'(d);
    recomb = {1'b0, prod} + {9'b0, r};
    return (recomb != {1'b0, n}) | (r >= d);
  endfunction
`endif

  // Handshake and operand screening; in_ready follows out_ready only in HOLD.
  always_comb begin
    in_ready = rdy_p0 | ((state == HOLD) & out_ready);
    accept   = in_valid & in_ready;
    dz_c     = (in_d == 8'd0);
    ovf_c    = !dz_c && (in_n[15:8] >= in_d);
  end

  // Residual check at capture. Overflowed pairs are skipped, and dz pairs
  // never reach capture.
  always_comb begin
`ifdef DIV_RESID_CHECK_EN
    err_c = ovf_p1 ? 1'b0 : resid_err(arr_n, arr_d, arr_q, arr_r);
`else
    err_c = 1'b0;
`endif
  end

  // Sequencer FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      rdy_p0    <= 1'b0;
      ovf_p1    <= 1'b0;
      arr_n     <= 16'd0;
      arr_d     <= 8'd0;
      out_valid <= 1'b0;
      out_q     <= 8'd0;
      out_r     <= 8'd0;
      out_dz    <= 1'b0;
      out_ovf   <= 1'b0;
      out_err   <= 1'b0;
    end else if (accept) begin
      // Issue: operands onto the array, flags registered with them
      arr_n  <= in_n;
      arr_d  <= in_d;
      ovf_p1 <= ovf_c;
      rdy_p0 <= 1'b0;
      if (dz_c) begin
        state     <= HOLD;
        out_valid <= 1'b1;
        out_q     <= 8'hFF;
        out_r     <= in_n[7:0];
        out_dz    <= 1'b1;
        out_ovf   <= 1'b0;
        out_err   <= 1'b0;
      end else begin
        state     <= SETTLE;
        cnt       <= CNT_INIT;
        out_valid <= 1'b0;
      end
    end else begin
      case (state)
        IDLE: begin
          rdy_p0 <= 1'b1;
        end
        SETTLE: begin
          // Capture: array outputs have settled on the held operands
          if (cnt == 4'd0) begin
            state     <= HOLD;
            out_valid <= 1'b1;
            out_q     <= arr_q;
            out_r     <= arr_r;
            out_dz    <= 1'b0;
            out_ovf   <= ovf_p1;
            out_err   <= err_c;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        HOLD: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            rdy_p0    <= 1'b1;
          end
        end
        default: begin
          state  <= IDLE;
          rdy_p0 <= 1'b1;
        end
      endcase
    end
  end

endmodule
